// File: rtl/atmega_io_master_if.sv
// -----------------------------------------------------------------------------
// atmega_io_master_if
// Bundles the host command/response channels and the ATmega-style IO register
// bus driven by atmega_io_master.
//
// Valid/ready semantics (cmd and rsp channels): a transfer happens on a rising
// clk edge where valid & ready are both high. A source holds valid and its
// payload stable until that edge. A sink may assert or drop ready freely.
//
// Signals:
//   cmd_valid/cmd_ready/cmd_op/cmd_addr/cmd_data/cmd_mask  host command
//   rsp_valid/rsp_ready/rsp_data/rsp_err                   host response
//   io_addr/io_wr/io_rd/io_wdata/io_rdata                  IO register bus
//   busy       master is not idle
//   dbg_state  master FSM state (IDLE=0, RD=1, WR=2, RESP=3)
// Modports:
//   master - the bus initiator (atmega_io_master)
//   slave  - the host and the peripherals seen from the other side
// -----------------------------------------------------------------------------
interface atmega_io_master_if #(
  parameter int BUS_ADDR_DATA_LEN = 8,
  parameter int BUS_WIDTH         = 8
);
  logic                         cmd_valid;
  logic                         cmd_ready;
  logic [2:0]                   cmd_op;
  logic [BUS_ADDR_DATA_LEN-1:0] cmd_addr;
  logic [BUS_WIDTH-1:0]         cmd_data;
  logic [BUS_WIDTH-1:0]         cmd_mask;

  logic                         rsp_valid;
  logic                         rsp_ready;
  logic [BUS_WIDTH-1:0]         rsp_data;
  logic                         rsp_err;

  logic [BUS_ADDR_DATA_LEN-1:0] io_addr;
  logic                         io_wr;
  logic                         io_rd;
  logic [BUS_WIDTH-1:0]         io_wdata;
  logic [BUS_WIDTH-1:0]         io_rdata;

  logic                         busy;
  logic [1:0]                   dbg_state;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_mask,
    input  rsp_ready, io_rdata,
    output cmd_ready, rsp_valid, rsp_data, rsp_err,
    output io_addr, io_wr, io_rd, io_wdata,
    output busy, dbg_state
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_mask,
    output rsp_ready, io_rdata,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err,
    input  io_addr, io_wr, io_rd, io_wdata,
    input  busy, dbg_state
  );
endinterface

// File: rtl/atmega_io_master.sv
// -----------------------------------------------------------------------------
// atmega_io_master
// Bus initiator for the ATmega-style IO register bus. Takes one host command at
// a time (WRITE, READ, SET, CLR, TOG, WRMASK), runs the IO bus cycles for it and
// returns exactly one response. Read-modify-write ops keep the bus to
// themselves from the read strobe to the write strobe, so they are atomic.
//
// Ports:
//   clk  clock
//   rst  synchronous, active-high reset
//   bus  atmega_io_master_if.master: cmd/rsp channels, IO bus, busy, dbg_state
//
// Parameters:
//   BUS_ADDR_DATA_LEN  address width
//   BUS_WIDTH          data width
//   RD_LATENCY         extra io_rd cycles before read data is sampled (0..3)
//
// Build option:
//   ATMEGA_IO_MASTER_RMW_EN  when defined, ops 2-5 (SET/CLR/TOG/WRMASK) are
//                            built; otherwise they are answered as illegal ops.
//
// All outputs are registered except cmd_ready = (state == IDLE) & ~rst.
// -----------------------------------------------------------------------------
module atmega_io_master #(
  parameter int BUS_ADDR_DATA_LEN = 8,
  parameter int BUS_WIDTH         = 8,
  parameter int RD_LATENCY        = 0
) (
  input logic                clk,
  input logic                rst,
  atmega_io_master_if.master bus
);

  localparam logic [2:0] OP_WRITE  = 3'd0;
  localparam logic [2:0] OP_READ   = 3'd1;
`ifdef ATMEGA_IO_MASTER_RMW_EN
  localparam logic [2:0] OP_SET    = 3'd2;
  localparam logic [2:0] OP_CLR    = 3'd3;
  localparam logic [2:0] OP_TOG    = 3'd4;
  localparam logic [2:0] OP_WRMASK = 3'd5;
`endif

  // Value of the read counter on the cycle io_rdata is sampled.
  localparam logic [1:0] LAST_RD = 2'(RD_LATENCY);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t                       state, state_d;
  logic [1:0]                   rd_cnt, rd_cnt_d;
  logic [BUS_ADDR_DATA_LEN-1:0] io_addr_q, io_addr_d;
  logic                         io_wr_q, io_wr_d;
  logic                         io_rd_q, io_rd_d;
  logic [BUS_WIDTH-1:0]         io_wdata_q, io_wdata_d;
  logic                         rsp_valid_q, rsp_valid_d;
  logic [BUS_WIDTH-1:0]         rsp_data_q, rsp_data_d;
  logic                         rsp_err_q, rsp_err_d;
  logic                         busy_q, busy_d;
  logic                         cmd_ready;
  logic                         accept;

`ifdef ATMEGA_IO_MASTER_RMW_EN
  logic [2:0]                   op_q, op_d;
  logic [BUS_WIDTH-1:0]         data_q, data_d;
  logic [BUS_WIDTH-1:0]         mask_q, mask_d;

  function automatic logic [BUS_WIDTH-1:0] modify(
    input logic [2:0]           op,
    input logic [BUS_WIDTH-1:0] r,
    input logic [BUS_WIDTH-1:0] d,
    input logic [BUS_WIDTH-1:0] m
  );
    case (op)
      OP_SET:    modify = r | d;
      OP_CLR:    modify = r & ~d;
      OP_TOG:    modify = r ^ d;
      OP_WRMASK: modify = (r & ~m) | (d & m);
      default:   modify = r;
    endcase
  endfunction
`endif

  assign cmd_ready = (state == IDLE) & ~rst;
  assign accept    = bus.cmd_valid & cmd_ready;

  // Next-state and next-output logic. Strobes default low so that each
  // strobe cycle is explicitly requested by the state that needs it.
  always_comb begin
    state_d     = state;
    rd_cnt_d    = rd_cnt;
    io_addr_d   = io_addr_q;
    io_wr_d     = 1'b0;
    io_rd_d     = 1'b0;
    io_wdata_d  = io_wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
`ifdef ATMEGA_IO_MASTER_RMW_EN
    op_d        = op_q;
    data_d      = data_q;
    mask_d      = mask_q;
`endif

    case (state)
      IDLE: begin
        if (accept) begin
          io_addr_d = bus.cmd_addr;
`ifdef ATMEGA_IO_MASTER_RMW_EN
          op_d      = bus.cmd_op;
          data_d    = bus.cmd_data;
          mask_d    = bus.cmd_mask;
`endif
          case (bus.cmd_op)
            OP_WRITE: begin
              state_d    = WR;
              io_wr_d    = 1'b1;
              io_wdata_d = bus.cmd_data;
            end
`ifdef ATMEGA_IO_MASTER_RMW_EN
            OP_READ, OP_SET, OP_CLR, OP_TOG, OP_WRMASK: begin
`else
            OP_READ: begin
`endif
              state_d  = RD;
              io_rd_d  = 1'b1;
              rd_cnt_d = 2'd0;
            end
            default: begin
              // Illegal or not-built op: answer straight away, no bus cycle.
              state_d     = RESP;
              rsp_valid_d = 1'b1;
              rsp_err_d   = 1'b1;
              rsp_data_d  = '0;
            end
          endcase
        end
      end

      RD: begin
        if (rd_cnt == LAST_RD) begin
`ifdef ATMEGA_IO_MASTER_RMW_EN
          if (op_q != OP_READ) begin
            // The modified value goes straight into the write-data register
            // so the write strobe follows the last read strobe back to back.
            state_d    = WR;
            io_wr_d    = 1'b1;
            io_wdata_d = modify(op_q, bus.io_rdata, data_q, mask_q);
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_data_d  = bus.io_rdata;
          end
`else
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_data_d  = bus.io_rdata;
`endif
        end else begin
          rd_cnt_d = rd_cnt + 2'd1;
          io_rd_d  = 1'b1;
        end
      end

      WR: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_data_d  = io_wdata_q;
      end

      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rd_cnt      <= 2'd0;
      io_addr_q   <= '0;
      io_wr_q     <= 1'b0;
      io_rd_q     <= 1'b0;
      io_wdata_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
`ifdef ATMEGA_IO_MASTER_RMW_EN
      op_q        <= 3'd0;
      data_q      <= '0;
      mask_q      <= '0;
`endif
    end else begin
      state       <= state_d;
      rd_cnt      <= rd_cnt_d;
      io_addr_q   <= io_addr_d;
      io_wr_q     <= io_wr_d;
      io_rd_q     <= io_rd_d;
      io_wdata_q  <= io_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
`ifdef ATMEGA_IO_MASTER_RMW_EN
      op_q        <= op_d;
      data_q      <= data_d;
      mask_q      <= mask_d;
`endif
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.io_addr   = io_addr_q;
  assign bus.io_wr     = io_wr_q;
  assign bus.io_rd     = io_rd_q;
  assign bus.io_wdata  = io_wdata_q;
  assign bus.busy      = busy_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_atmega_io_master.sv
// -----------------------------------------------------------------------------
// tb_atmega_io_master
// Two masters share one register-file peripheral model: dut0 with RD_LATENCY 0
// and dut2 with RD_LATENCY 2. 'sel' routes host stimulus to one of them and
// the o_* wires show the selected master's outputs. Expected responses, strobe
// timing and register contents come from a command-level reference model.
// -----------------------------------------------------------------------------
module tb_atmega_io_master;

`ifdef ATMEGA_IO_MASTER_RMW_EN
  localparam bit RMW_BUILT = 1'b1;
`else
  localparam bit RMW_BUILT = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  atmega_io_master_if #(.BUS_ADDR_DATA_LEN(8), .BUS_WIDTH(8)) b0 ();
  atmega_io_master_if #(.BUS_ADDR_DATA_LEN(8), .BUS_WIDTH(8)) b2 ();

  atmega_io_master #(.BUS_ADDR_DATA_LEN(8), .BUS_WIDTH(8), .RD_LATENCY(0))
    dut0 (.clk(clk), .rst(rst), .bus(b0));
  atmega_io_master #(.BUS_ADDR_DATA_LEN(8), .BUS_WIDTH(8), .RD_LATENCY(2))
    dut2 (.clk(clk), .rst(rst), .bus(b2));

  // ---------------- host side ----------------
  logic       sel;
  logic       cmd_valid;
  logic [2:0] cmd_op;
  logic [7:0] cmd_addr, cmd_data, cmd_mask;
  logic       rsp_ready;

  assign b0.cmd_valid = cmd_valid & ~sel;
  assign b2.cmd_valid = cmd_valid & sel;
  assign b0.rsp_ready = rsp_ready & ~sel;
  assign b2.rsp_ready = rsp_ready & sel;
  assign b0.cmd_op = cmd_op;     assign b2.cmd_op = cmd_op;
  assign b0.cmd_addr = cmd_addr; assign b2.cmd_addr = cmd_addr;
  assign b0.cmd_data = cmd_data; assign b2.cmd_data = cmd_data;
  assign b0.cmd_mask = cmd_mask; assign b2.cmd_mask = cmd_mask;

  logic       o_cmd_ready, o_rsp_valid, o_rsp_err, o_io_wr, o_io_rd, o_busy;
  logic [7:0] o_rsp_data, o_io_addr, o_io_wdata;
  assign o_cmd_ready = sel ? b2.cmd_ready : b0.cmd_ready;
  assign o_rsp_valid = sel ? b2.rsp_valid : b0.rsp_valid;
  assign o_rsp_err   = sel ? b2.rsp_err   : b0.rsp_err;
  assign o_rsp_data  = sel ? b2.rsp_data  : b0.rsp_data;
  assign o_io_wr     = sel ? b2.io_wr     : b0.io_wr;
  assign o_io_rd     = sel ? b2.io_rd     : b0.io_rd;
  assign o_io_addr   = sel ? b2.io_addr   : b0.io_addr;
  assign o_io_wdata  = sel ? b2.io_wdata  : b0.io_wdata;
  assign o_busy      = sel ? b2.busy      : b0.busy;

  // ---------------- peripheral: register file with combinational read-back
  logic [7:0] periph [0:255];
  assign b0.io_rdata = periph[b0.io_addr];
  assign b2.io_rdata = periph[b2.io_addr];
  always @(posedge clk) begin
    if (b0.io_wr) periph[b0.io_addr] <= b0.io_wdata;
    if (b2.io_wr) periph[b2.io_addr] <= b2.io_wdata;
  end

  // ---------------- scoreboard state ----------------
  logic [7:0] ref_mem [0:255];
  int n_checks = 0;
  int n_fail   = 0;
  int last_wait;

  // Command-level reference: what a command does to a register whose
  // current value is 'old', and what the host gets back.
  function automatic void model(input logic [2:0] op, input logic [7:0] old,
                                input logic [7:0] d, input logic [7:0] m,
                                output bit err, output bit rd, output bit wr,
                                output logic [7:0] wval, output logic [7:0] rsp);
    err = 1'b0; rd = 1'b0; wr = 1'b0; wval = 8'h00; rsp = 8'h00;
    if (op == 3'd0) begin
      wr = 1'b1; wval = d; rsp = d;
    end else if (op == 3'd1) begin
      rd = 1'b1; rsp = old;
    end else if (op >= 3'd2 && op <= 3'd5 && RMW_BUILT) begin
      rd = 1'b1; wr = 1'b1;
      case (op)
        3'd2:    wval = old | d;
        3'd3:    wval = old & ~d;
        3'd4:    wval = old ^ d;
        default: wval = (old & ~m) | (d & m);
      endcase
      rsp = wval;
    end else begin
      err = 1'b1;
    end
  endfunction

  // ---------------- driver: one full command with its own checks ----------
  // Called at a negedge. 'hold' = cycles rsp_ready stays low once rsp_valid
  // shows (0 = rsp_ready already high). 'pend' keeps a WRITE request on
  // cmd_valid after acceptance, to probe that nothing is accepted early.
  task automatic do_cmd(input logic [2:0] op, input logic [7:0] addr,
                        input logic [7:0] d, input logic [7:0] m,
                        input int hold, input bit pend);
    int lat, exp_rsp_k, exp_wr_k, exp_rd_n;
    int w, k, rsp_k, rd_n, rd_first, wr_n, wr_k;
    bit e_err, e_rd, e_wr, rule_bad, hold_bad, hs_bad;
    logic [7:0] e_wval, e_rsp, got_wval, got_data;
    logic got_err;
    lat = sel ? 2 : 0;
    model(op, ref_mem[addr], d, m, e_err, e_rd, e_wr, e_wval, e_rsp);
    exp_rd_n  = e_rd ? lat + 1 : 0;
    exp_wr_k  = e_rd ? lat + 2 : 1;
    exp_rsp_k = e_err ? 1 : (e_rd && e_wr) ? lat + 3 : e_rd ? lat + 2 : 2;

    rsp_ready = (hold == 0);
    cmd_op = op; cmd_addr = addr; cmd_data = d; cmd_mask = m;
    cmd_valid = 1'b1;
    w = 0;
    while (!o_cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    last_wait = w;
    if (!o_cmd_ready) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout op=%0d addr=%h: cmd_ready low for %0d cycles, required high", op, addr, w);
      cmd_valid = 1'b0;
      return;
    end

    k = 0; rsp_k = 0; rd_n = 0; rd_first = 0; wr_n = 0; wr_k = 0;
    got_wval = 8'h00; got_data = 8'h00; got_err = 1'b0; rule_bad = 1'b0;
    while (rsp_k == 0 && k < 30) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        cmd_valid = pend;
        if (pend) cmd_op = 3'd0;
      end
      if (o_io_rd) begin
        rd_n++;
        if (rd_first == 0) rd_first = k;
        if (o_io_addr !== addr) rule_bad = 1'b1;
      end
      if (o_io_wr) begin
        wr_n++; wr_k = k; got_wval = o_io_wdata;
        if (o_io_addr !== addr) rule_bad = 1'b1;
      end
      if (o_io_rd && o_io_wr) rule_bad = 1'b1;
      if (!o_busy || o_cmd_ready) rule_bad = 1'b1;
      if (o_rsp_valid) begin
        rsp_k = k; got_data = o_rsp_data; got_err = o_rsp_err;
      end
    end

    hold_bad = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (!o_rsp_valid || o_rsp_data !== got_data || o_rsp_err !== got_err ||
          o_cmd_ready || o_io_wr || o_io_rd || !o_busy) hold_bad = 1'b1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    hs_bad = o_rsp_valid || !o_cmd_ready || o_busy;
    if (e_wr) ref_mem[addr] = e_wval;

    n_checks++;
    if (rsp_k !== exp_rsp_k) begin
      n_fail++;
      $display("FAIL rsp_timing op=%0d addr=%h lat=%0d: rsp_valid at cycle %0d, required %0d", op, addr, lat, rsp_k, exp_rsp_k);
    end
    n_checks++;
    if (got_err !== e_err || got_data !== e_rsp) begin
      n_fail++;
      $display("FAIL rsp_value op=%0d addr=%h: err=%0b data=%h, required err=%0b data=%h", op, addr, got_err, got_data, e_err, e_rsp);
    end
    n_checks++;
    if (rd_n !== exp_rd_n || (exp_rd_n > 0 && rd_first !== 1)) begin
      n_fail++;
      $display("FAIL rd_strobe op=%0d lat=%0d: %0d cycles from cycle %0d, required %0d from cycle 1", op, lat, rd_n, rd_first, exp_rd_n);
    end
    n_checks++;
    if (wr_n !== int'(e_wr) || (e_wr && (wr_k !== exp_wr_k || got_wval !== e_wval))) begin
      n_fail++;
      $display("FAIL wr_strobe op=%0d lat=%0d: %0d strobes at cycle %0d wdata=%h, required %0d at cycle %0d wdata=%h", op, lat, wr_n, wr_k, got_wval, e_wr, exp_wr_k, e_wval);
    end
    n_checks++;
    if (rule_bad) begin
      n_fail++;
      $display("FAIL bus_rules op=%0d addr=%h: addr/strobe/busy/cmd_ready rule broken=1, required 0", op, addr);
    end
    if (hold > 0) begin
      n_checks++;
      if (hold_bad) begin
        n_fail++;
        $display("FAIL rsp_hold op=%0d hold=%0d: response unstable or bus active=1, required 0", op, hold);
      end
    end
    n_checks++;
    if (hs_bad) begin
      n_fail++;
      $display("FAIL handshake op=%0d: rsp_valid=%0b cmd_ready=%0b busy=%0b, required 0 1 0", op, o_rsp_valid, o_cmd_ready, o_busy);
    end
    if (e_wr) begin
      n_checks++;
      if (periph[addr] !== ref_mem[addr]) begin
        n_fail++;
        $display("FAIL reg_content op=%0d addr=%h: %h, required %h", op, addr, periph[addr], ref_mem[addr]);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({b0.io_addr, b0.io_wdata, b0.rsp_data, b0.io_wr, b0.io_rd, b0.rsp_valid,
         b0.rsp_err, b0.busy, b0.cmd_ready} !== 29'd0 ||
        {b2.io_addr, b2.io_wdata, b2.rsp_data, b2.io_wr, b2.io_rd, b2.rsp_valid,
         b2.rsp_err, b2.busy, b2.cmd_ready} !== 29'd0) begin
      n_fail++;
      $display("FAIL reset_values: dut0 rsp_valid=%0b busy=%0b cmd_ready=%0b, dut2 rsp_valid=%0b busy=%0b cmd_ready=%0b, required all 0",
               b0.rsp_valid, b0.busy, b0.cmd_ready, b2.rsp_valid, b2.busy, b2.cmd_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (b0.cmd_ready !== 1'b1 || b2.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_reset: %0b %0b, required 1 1", b0.cmd_ready, b2.cmd_ready);
    end
  endtask

  task automatic test_write();
    sel = 1'b0;
    do_cmd(3'd0, 8'h03, 8'hA5, 8'h00, 0, 1'b0);
  endtask

  task automatic test_read();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      do_cmd(3'd0, 8'h04, 8'h3C, 8'h00, 0, 1'b0);
      do_cmd(3'd1, 8'h04, 8'h00, 8'h00, 0, 1'b0);
    end
  endtask

  task automatic test_rmw();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      do_cmd(3'd0, 8'h00, 8'h10, 8'h00, 0, 1'b0);
      do_cmd(3'd2, 8'h00, 8'h81, 8'h00, 0, 1'b0);
      do_cmd(3'd3, 8'h00, 8'h10, 8'h00, 1, 1'b0);
      do_cmd(3'd4, 8'h00, 8'hFF, 8'h00, 0, 1'b0);
      do_cmd(3'd1, 8'h00, 8'h00, 8'h00, 0, 1'b0);
      do_cmd(3'd0, 8'h01, 8'hF0, 8'h00, 0, 1'b0);
      do_cmd(3'd5, 8'h01, 8'h0F, 8'h3C, 2, 1'b0);
      do_cmd(3'd1, 8'h01, 8'h00, 8'h00, 0, 1'b0);
    end
  endtask

  task automatic test_illegal();
    sel = 1'b0;
    do_cmd(3'd7, 8'h02, 8'hFF, 8'hFF, 0, 1'b0);
    do_cmd(3'd6, 8'h02, 8'h12, 8'h00, 2, 1'b0);
    sel = 1'b1;
    do_cmd(3'd7, 8'h09, 8'h55, 8'h00, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    do_cmd(3'd1, 8'h04, 8'h00, 8'h00, 5, 1'b1);
    do_cmd(3'd0, 8'h05, 8'h5A, 8'h00, 0, 1'b0);
    n_checks++;
    if (last_wait !== 0) begin
      n_fail++;
      $display("FAIL accept_after_handshake: waited %0d cycles, required 0", last_wait);
    end
  endtask

  task automatic test_reset_mid();
    bit bad;
    int w;
    sel = 1'b1;
    rsp_ready = 1'b1;
    cmd_op = RMW_BUILT ? 3'd4 : 3'd1;
    cmd_addr = 8'h04; cmd_data = 8'hFF; cmd_mask = 8'h00;
    cmd_valid = 1'b1;
    w = 0;
    while (!o_cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    n_checks++;
    if (o_io_rd !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_rd_phase: io_rd=%0b, required 1", o_io_rd);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({o_io_addr, o_io_wdata, o_rsp_data, o_io_wr, o_io_rd, o_rsp_valid,
         o_rsp_err, o_busy, o_cmd_ready} !== 29'd0) begin
      n_fail++;
      $display("FAIL mid_reset_values: io_rd=%0b io_wr=%0b rsp_valid=%0b busy=%0b cmd_ready=%0b io_addr=%h, required all 0",
               o_io_rd, o_io_wr, o_rsp_valid, o_busy, o_cmd_ready, o_io_addr);
    end
    @(negedge clk);
    n_checks++;
    if (o_cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_in_reset: %0b, required 0", o_cmd_ready);
    end
    rst = 1'b0;
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (o_rsp_valid || o_io_wr || o_io_rd || o_busy) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL mid_reset_quiet: stray activity=1, required 0");
    end
    do_cmd(3'd0, 8'h04, 8'h66, 8'h00, 1, 1'b0);
  endtask

  task automatic test_random();
    for (int a = 0; a < 16; a++) begin
      sel = a[0];
      do_cmd(3'd0, 8'(a), 8'($urandom_range(0, 255)), 8'h00, 0, 1'b0);
    end
    for (int i = 0; i < 40; i++) begin
      sel = 1'($urandom_range(0, 1));
      do_cmd(3'($urandom_range(0, 7)), 8'($urandom_range(0, 15)),
             8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             $urandom_range(0, 3), 1'b0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    sel = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0;
    cmd_addr = 8'h00; cmd_data = 8'h00; cmd_mask = 8'h00; rsp_ready = 1'b0;
    last_wait = 0;
    test_reset();
    test_write();
    test_read();
    test_rmw();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/atmega_io_master.md
Name: atmega_io_master

Overview:
Bus initiator for the ATmega-style IO register bus (addr/wr/rd/write-data/read-data) that the PIO and other IO peripherals respond on. It accepts single commands from a host-side valid/ready interface and sequences the IO bus cycles for each one: write, read, or atomic read-modify-write (set, clear, toggle, masked write). It returns one response per command. It sits between a soft-core, debug bridge or DMA and the IO peripheral bus.

Parameters:
BUS_ADDR_DATA_LEN, 8, width of io_addr and cmd_addr
BUS_WIDTH, 8, data width of the IO bus and of the command data, mask and response data
RD_LATENCY, 0, extra cycles io_rd stays asserted before read data is sampled; legal range 0..3; 0 suits combinational peripheral read-back

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted when cmd_valid & cmd_ready
cmd_op  input  3  0 WRITE, 1 READ, 2 SET, 3 CLR, 4 TOG, 5 WRMASK, 6-7 illegal
cmd_addr  input  BUS_ADDR_DATA_LEN  target register address
cmd_data  input  BUS_WIDTH  write data; bit mask for SET, CLR and TOG
cmd_mask  input  BUS_WIDTH  bit mask for WRMASK only
rsp_valid  output  1  response present
rsp_ready  input  1  response consumed when rsp_valid & rsp_ready
rsp_data  output  BUS_WIDTH  read value (READ), written value (WRITE and RMW ops), 0 on error
rsp_err  output  1  illegal or disabled opcode
io_addr  output  BUS_ADDR_DATA_LEN  IO bus address
io_wr  output  1  IO write strobe, one cycle
io_rd  output  1  IO read strobe
io_wdata  output  BUS_WIDTH  to peripheral write-data input
io_rdata  input  BUS_WIDTH  from peripheral read-data output
busy  output  1  state != IDLE

Behaviour:
- All outputs are registered except cmd_ready = (state==IDLE) & ~rst.
- Reset values: io_addr, io_wdata, rsp_data = 0; io_wr, io_rd, rsp_valid, rsp_err, busy = 0; state = IDLE; internal read counter = 0.
- FSM states: IDLE, RD, WR, RESP.
- IDLE: on accept, register op, addr, data and mask, and drive io_addr = cmd_addr.
  - WRITE goes to WR.
  - READ, SET, CLR, TOG and WRMASK go to RD.
  - Illegal ops go to RESP with rsp_err = 1, rsp_data = 0 and no bus activity.
- RD: io_rd = 1 for RD_LATENCY+1 consecutive cycles. Capture io_rdata on the last of these cycles.
  - READ then goes to RESP with rsp_data = captured value.
  - RMW ops then go to WR.
- Modify rules, computed in the cycle after capture (r = captured read value):
  - SET: r | data
  - CLR: r & ~data
  - TOG: r ^ data
  - WRMASK: (r & ~mask) | (data & mask)
- WR: io_wr = 1 for exactly one cycle, with io_wdata = cmd_data (WRITE) or the modified value. Then go to RESP with rsp_data = io_wdata.
- RESP: rsp_valid = 1. rsp_data and rsp_err stay stable until rsp_ready; on handshake go to IDLE.
- Latency, with the accept edge at cycle N:
  - WRITE: io_wr in N+1, rsp_valid from N+2.
  - READ: io_rd in N+1..N+1+L, rsp_valid from N+2+L.
  - RMW: io_rd in N+1..N+1+L, io_wr in N+2+L, rsp_valid from N+3+L.
  - L = RD_LATENCY.
- Only one command is outstanding at a time. cmd_ready = 0 outside IDLE, including the RESP cycle in which rsp_ready is sampled.
- io_wr and io_rd are never high in the same cycle. io_addr is stable from the first strobe cycle through the last strobe cycle of a command. No RMW bus cycle is interleaved with another command, so RMW is atomic on the IO bus.
- Outside RD/WR, io_addr and io_wdata hold their last values. io_wr and io_rd are 0.
- Reset mid-operation: the state returns to IDLE at the reset edge. Strobes drop on the following cycle, the pending response is discarded and never issued, and cmd_ready stays low while rst is high.
- If rsp_ready is already high on the first RESP cycle, the handshake completes in that cycle.

Optional Feature:
ATMEGA_IO_MASTER_RMW_EN
- Defined: ops 2-5 are supported as described above.
- Undefined: the modify datapath and RD-to-WR path are not built. Ops 2-5 behave as illegal: no bus cycle, rsp_err = 1, rsp_data = 0. WRITE and READ are unchanged.

Test Plan:
- WRITE addr 0x03, data 0xA5, rsp_ready = 1 -> io_wr high for exactly 1 cycle at N+1 with io_addr 0x03 and io_wdata 0xA5; rsp_valid at N+2, rsp_data 0xA5, rsp_err 0.
- READ addr 0x04, io_rdata 0x3C, RD_LATENCY = 0 and then 2 -> io_rd high for 1 and 3 cycles respectively; rsp_data 0x3C; io_wr never asserted.
- SET addr 0x00, data 0x81, read value 0x10 -> io_wr with wdata 0x91. CLR data 0x10 on 0x91 -> 0x81. TOG data 0xFF on 0x81 -> 0x7E. WRMASK data 0x0F, mask 0x3C on 0xF0 -> 0xCC.
- cmd_op = 7, and ops 2-5 with ATMEGA_IO_MASTER_RMW_EN undefined -> no io_rd/io_wr; rsp_err 1, rsp_data 0.
- rsp_ready held low for 5 cycles in RESP -> rsp_valid and rsp_data stable, cmd_ready 0, a second cmd_valid not accepted until the cycle after the handshake.
- rst asserted during the RD phase of a TOG -> no io_wr, no rsp_valid, all outputs at reset values; a following WRITE completes normally.
